// File: rtl/decode_stage.sv
// ID stage of the 8-bit pipeline: instruction decode, 8x8 register file with
// write-through bypass, load-use interlock with a one-entry hold register, and jump redirect.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] if_instr,
  input  logic [7:0]  if_pc,
  input  logic        if_valid,
  input  logic        ex_flush,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [7:0]  wb_data,
  output logic        fetch_stall,
  output logic        fetch_flush,
  output logic [7:0]  fetch_target,
  output logic        halt,
  output logic        id_valid,
  output logic [3:0]  id_op,
  output logic [2:0]  id_rd,
  output logic [2:0]  id_rs1,
  output logic [2:0]  id_rs2,
  output logic [7:0]  id_a,
  output logic [7:0]  id_b,
  output logic [7:0]  id_imm,
  output logic [7:0]  id_pc,
  output logic        id_we,
  output logic        id_mem_rd,
  output logic        id_mem_wr,
  output logic        id_branch,
  output logic        id_illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_BNEZ = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [7:0]  rf [0:7];

  logic        hold_valid;
  logic [15:0] hold_instr;
  logic [7:0]  hold_pc;

  logic [15:0] cur_instr;
  logic [7:0]  cur_pc;
  logic        cur_valid;
  logic [3:0]  opc;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs2;
  logic [2:0]  src_a;
  logic        is_alu;
  logic        is_branch;
  logic        use_a;
  logic        use_b;
  logic        hazard;
  logic        stall;
  logic [7:0]  rd_a;
  logic [7:0]  rd_b;

  // The held copy takes precedence over fetch while it is waiting to issue.
  assign cur_instr = hold_valid ? hold_instr : if_instr;
  assign cur_pc    = hold_valid ? hold_pc    : if_pc;
  assign cur_valid = hold_valid | if_valid;

  assign opc       = cur_instr[15:12];
  assign f_rd      = cur_instr[11:9];
  assign f_rs2     = cur_instr[5:3];
  assign is_alu    = (opc >= 4'h1) && (opc <= 4'h7);
  assign is_branch = (opc == OP_BEQZ) || (opc == OP_BNEZ);
  assign src_a     = is_branch ? f_rd : cur_instr[8:6];
  assign use_a     = is_alu || is_branch || (opc == OP_LD) || (opc == OP_ST);
  assign use_b     = is_alu || (opc == OP_ST);

  assign hazard = cur_valid && id_valid && id_mem_rd && (id_rd != 3'd0) &&
                  ((use_a && (src_a == id_rd)) || (use_b && (f_rs2 == id_rd)));
  assign stall  = halt || hazard;

  assign fetch_stall  = !reset && !ex_flush && stall;
  assign fetch_flush  = !reset && !ex_flush && !stall && cur_valid && (opc == OP_JMP);
  assign fetch_target = reset ? 8'h00 : cur_instr[11:4];

  always_comb begin
    rd_a = 8'h00;
    rd_b = 8'h00;
    if (src_a != 3'd0)
      rd_a = (wb_we && (wb_rd == src_a)) ? wb_data : rf[src_a];
    if (f_rs2 != 3'd0)
      rd_b = (wb_we && (wb_rd == f_rs2)) ? wb_data : rf[f_rs2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      hold_valid <= 1'b0;
      hold_instr <= 16'h0000;
      hold_pc    <= 8'h00;
      halt       <= 1'b0;
      id_valid   <= 1'b0;
      id_op      <= 4'h0;
      id_rd      <= 3'd0;
      id_rs1     <= 3'd0;
      id_rs2     <= 3'd0;
      id_a       <= 8'h00;
      id_b       <= 8'h00;
      id_imm     <= 8'h00;
      id_pc      <= 8'h00;
      id_we      <= 1'b0;
      id_mem_rd  <= 1'b0;
      id_mem_wr  <= 1'b0;
      id_branch  <= 1'b0;
      id_illegal <= 1'b0;
    end else begin
      if (wb_we && (wb_rd != 3'd0))
        rf[wb_rd] <= wb_data;

      if (ex_flush || halt || hazard || !cur_valid) begin
        id_valid   <= 1'b0;
        id_we      <= 1'b0;
        id_mem_rd  <= 1'b0;
        id_mem_wr  <= 1'b0;
        id_branch  <= 1'b0;
        id_illegal <= 1'b0;
        if (ex_flush) begin
          hold_valid <= 1'b0;
        end else if (!halt && hazard && !hold_valid) begin
          hold_valid <= if_valid;
          hold_instr <= if_instr;
          hold_pc    <= if_pc;
        end
      end else begin
        hold_valid <= 1'b0;
        id_valid   <= 1'b1;
        // JMP, illegal and HALT all travel down the pipe as NOPs.
        id_op      <= (opc >= OP_JMP) ? OP_NOP : opc;
        id_rd      <= f_rd;
        id_rs1     <= src_a;
        id_rs2     <= f_rs2;
        id_a       <= rd_a;
        id_b       <= rd_b;
        id_imm     <= cur_instr[7:0];
        id_pc      <= cur_pc;
        id_we      <= is_alu || (opc == OP_LDI) || (opc == OP_LD);
        id_mem_rd  <= (opc == OP_LD);
        id_mem_wr  <= (opc == OP_ST);
        id_branch  <= is_branch;
        id_illegal <= (opc == OP_ILL);
        if (opc == OP_HALT)
          halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each scenario queues stimulus with its expected
// ID/EX bundle and fetch-side outputs, then replays the queue one cycle at a time.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid, ex_flush, wb_we;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        fetch_stall, fetch_flush, halt;
  logic [7:0]  fetch_target;
  logic        id_valid, id_we, id_mem_rd, id_mem_wr, id_branch, id_illegal;
  logic [3:0]  id_op;
  logic [2:0]  id_rd, id_rs1, id_rs2;
  logic [7:0]  id_a, id_b, id_imm, id_pc;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fetch_stall(fetch_stall), .fetch_flush(fetch_flush), .fetch_target(fetch_target),
    .halt(halt), .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc(id_pc),
    .id_we(id_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_branch(id_branch),
    .id_illegal(id_illegal)
  );

  // ctl = {we, mem_rd, mem_wr, branch, illegal}
  typedef struct packed {
    logic       h;
    logic       v;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] a, b, imm, pc;
    logic [4:0] ctl;
  } bund_t;

  typedef struct packed {
    logic       rst;
    logic [15:0] instr;
    logic [7:0] pc;
    logic       valid, fl, wwe;
    logic [2:0] wrd;
    logic [7:0] wd;
    logic       xs, xf;
    logic [7:0] xt;
  } stim_t;

  stim_t st_q[$];
  bund_t exp_q[$];
  bund_t msk_q[$];
  int    total = 0;
  int    bad   = 0;
  bund_t m_all, m_ctl, m_nop, m_r, m_i, m_br;

  function automatic bund_t mk(input int h, v, op, rd, rs1, rs2, a, b, imm, pc, ctl);
    bund_t r;
    r = {h[0], v[0], op[3:0], rd[2:0], rs1[2:0], rs2[2:0], a[7:0], b[7:0], imm[7:0], pc[7:0], ctl[4:0]};
    return r;
  endfunction

  function automatic logic [15:0] r_ins(input int op, rd, rs1, rs2);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] i_ins(input int op, rd, imm);
    return {op[3:0], rd[2:0], 1'b0, imm[7:0]};
  endfunction

  function automatic bund_t obs();
    return {halt, id_valid, id_op, id_rd, id_rs1, id_rs2, id_a, id_b, id_imm, id_pc,
            id_we, id_mem_rd, id_mem_wr, id_branch, id_illegal};
  endfunction

  task automatic push(input int rst, ins, pc, val, fl, wwe, wrd, wd, xs, xf, xt,
                      input bund_t e, input bund_t m);
    stim_t s;
    s = {rst[0], ins[15:0], pc[7:0], val[0], fl[0], wwe[0], wrd[2:0], wd[7:0], xs[0], xf[0], xt[7:0]};
    st_q.push_back(s);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; if_instr = s.instr; if_pc = s.pc; if_valid = s.valid;
    ex_flush = s.fl; wb_we = s.wwe; wb_rd = s.wrd; wb_data = s.wd;
  endtask

  task automatic test_reset();
    stim_t s; bund_t e, m;
    push(1, r_ins(1,1,3,3), 'h00, 1,0, 1,3,'hAA, 0,0,'h00, '0, m_all);
    push(1, 16'hD3C0,       'h00, 1,0, 0,0,0,    0,0,'h00, '0, m_all);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL reset_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL reset_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_bypass();
    stim_t s; bund_t e, m;
    push(0, r_ins(1,1,3,3),    'h01, 1,0, 1,3,'h05, 0,0,0, mk(0,1,1,1,3,3,'h05,'h05,0,'h01,'b10000), m_r);
    push(0, r_ins('hA,0,1,3),  'h02, 1,0, 1,1,'h20, 0,0,0, mk(0,1,'hA,0,1,3,'h20,'h05,0,'h02,'b00100), m_r);
    push(0, i_ins('hB,5,'h10), 'h03, 1,0, 1,5,'h99, 0,0,0, mk(0,1,'hB,0,5,0,'h99,0,'h10,'h03,'b00010), m_br);
    push(0, i_ins('hC,3,'h44), 'h04, 1,0, 0,0,0,    0,0,0, mk(0,1,'hC,0,3,0,'h05,0,'h44,'h04,'b00010), m_br);
    push(0, r_ins(4,6,5,1),    'h05, 1,0, 0,0,0,    0,0,0, mk(0,1,4,6,5,1,'h99,'h20,0,'h05,'b10000), m_r);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL bypass_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL bypass_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_load_use();
    stim_t s; bund_t e, m;
    push(0, r_ins(9,2,1,0),   'h10, 1,0, 0,0,0,    0,0,0, mk(0,1,9,2,1,0,'h20,0,0,'h10,'b11000), m_r);
    push(0, r_ins(1,4,2,0),   'h11, 1,0, 0,0,0,    1,0,0, '0, m_ctl);
    push(0, 16'h0000,         'h00, 0,0, 1,2,'h77, 0,0,0, mk(0,1,1,4,2,0,'h77,0,0,'h11,'b10000), m_r);
    push(0, 16'h0000,         'h00, 0,0, 0,0,0,    0,0,0, '0, m_ctl);
    push(0, r_ins(9,2,1,0),   'h12, 1,0, 0,0,0,    0,0,0, mk(0,1,9,2,1,0,'h20,0,0,'h12,'b11000), m_r);
    push(0, i_ins(8,2,'h33),  'h13, 1,0, 0,0,0,    0,0,0, mk(0,1,8,2,0,0,0,0,'h33,'h13,'b10000), m_i);
    push(0, r_ins(9,2,1,0),   'h14, 1,0, 0,0,0,    0,0,0, mk(0,1,9,2,1,0,'h20,0,0,'h14,'b11000), m_r);
    push(0, r_ins('hA,0,1,2), 'h15, 1,0, 0,0,0,    1,0,0, '0, m_ctl);
    push(0, 16'h0000,         'h00, 0,0, 0,0,0,    0,0,0, mk(0,1,'hA,0,1,2,'h20,'h77,0,'h15,'b00100), m_r);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL load_use_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL load_use_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_jump();
    stim_t s; bund_t e, m;
    push(0, 16'hD3C0,         'h05, 1,0, 0,0,0, 0,1,'h3C, mk(0,1,0,0,0,0,0,0,0,'h05,0), m_nop);
    push(0, i_ins(8,5,'hA5),  'h3C, 1,0, 0,0,0, 0,0,0,    mk(0,1,8,5,0,0,0,0,'hA5,'h3C,'b10000), m_i);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL jump_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL jump_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_flush();
    stim_t s; bund_t e, m;
    push(0, r_ins(9,2,1,0),  'h20, 1,0, 0,0,0, 0,0,0, mk(0,1,9,2,1,0,'h20,0,0,'h20,'b11000), m_r);
    push(0, r_ins(1,4,2,0),  'h21, 1,1, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, 16'h0000,        'h00, 0,0, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, 16'hD3C0,        'h22, 1,1, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, 16'hF000,        'h23, 1,1, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, 16'h0000,        'h00, 0,0, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, i_ins(8,3,'h11), 'h24, 1,0, 0,0,0, 0,0,0, mk(0,1,8,3,0,0,0,0,'h11,'h24,'b10000), m_i);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL flush_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL flush_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_illegal_r0();
    stim_t s; bund_t e, m;
    push(0, 16'hE000,       'h40, 1,0, 0,0,0,    0,0,0, mk(0,1,0,0,0,0,0,0,0,'h40,'b00001), m_nop);
    push(0, 16'h0000,       'h41, 1,0, 1,0,'h55, 0,0,0, mk(0,1,0,0,0,0,0,0,0,'h41,0), m_nop);
    push(0, r_ins(1,1,0,0), 'h42, 1,0, 1,0,'h66, 0,0,0, mk(0,1,1,1,0,0,0,0,0,'h42,'b10000), m_r);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL illegal_r0_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL illegal_r0_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  task automatic test_halt_reset();
    stim_t s; bund_t e, m;
    push(0, 16'hF000, 'h50, 1,0, 0,0,0, 0,0,0, mk(1,1,0,0,0,0,0,0,0,'h50,0), m_nop);
    for (int i = 0; i < 10; i++)
      push(0, r_ins(1,1,3,3), 'h51 + i, 1,0, 0,0,0, 1,0,0, mk(1,0,0,0,0,0,0,0,0,0,0), m_ctl);
    push(1, r_ins(1,1,3,3), 'h5B, 1,0, 0,0,0, 0,0,0, '0, m_all);
    push(0, 16'h0000,       'h00, 0,0, 0,0,0, 0,0,0, '0, m_ctl);
    push(0, r_ins(1,1,3,3), 'h60, 1,0, 0,0,0, 0,0,0, mk(0,1,1,1,3,3,0,0,0,'h60,'b10000), m_r);
    push(0, r_ins(9,2,1,0), 'h61, 1,0, 0,0,0, 0,0,0, mk(0,1,9,2,1,0,0,0,0,'h61,'b11000), m_r);
    push(0, r_ins(1,4,2,0), 'h62, 1,0, 0,0,0, 1,0,0, '0, m_ctl);
    push(1, 16'h0000,       'h00, 0,0, 0,0,0, 0,0,0, '0, m_all);
    push(0, 16'h0000,       'h00, 0,0, 0,0,0, 0,0,0, '0, m_ctl);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); apply(s); #1;
      total++;
      if (fetch_stall !== s.xs || fetch_flush !== s.xf || ((s.xf || s.rst) && fetch_target !== s.xt)) begin
        bad++; $display("FAIL halt_fetch: stall=%b flush=%b target=%h want %b %b %h", fetch_stall, fetch_flush, fetch_target, s.xs, s.xf, s.xt);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((obs() & m) !== (e & m)) begin bad++; $display("FAIL halt_id: got=%h want=%h mask=%h", obs(), e, m); end
    end
  endtask

  initial begin
    m_all = '1;
    m_ctl = mk(1,1,0,0,0,0,0,0,0,0,'h1F);
    m_nop = mk(1,1,'hF,0,0,0,0,0,0,'hFF,'h1F);
    m_r   = mk(1,1,'hF,7,7,7,'hFF,'hFF,0,'hFF,'h1F);
    m_i   = mk(1,1,'hF,7,0,0,0,0,'hFF,'hFF,'h1F);
    m_br  = mk(1,1,'hF,0,7,0,'hFF,0,'hFF,'hFF,'h1F);
    reset = 1'b1; if_instr = 16'h0000; if_pc = 8'h00; if_valid = 1'b0;
    ex_flush = 1'b0; wb_we = 1'b0; wb_rd = 3'd0; wb_data = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_load_use();
    test_jump();
    test_flush();
    test_illegal_r0();
    test_halt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the 8-bit pipelined microprocessor. Consumes the 16-bit instruction, PC and valid produced by the fetch stage. Decodes the instruction and reads the 8×8-bit register file, with a writeback port and write-through bypass. Detects load-use hazards, resolves unconditional jumps, and drives the registered ID/EX bundle to the execute stage.

## Interface
- No parameters. ISA fixed: 16-bit instructions, 8 registers, 8-bit PC and data.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_instr  in  16  instruction from fetch
- if_pc  in  8  PC of if_instr
- if_valid  in  1  if_instr is a real instruction
- ex_flush  in  1  taken branch resolved in execute; kill decode contents
- wb_we, wb_rd[2:0], wb_data[7:0]  in  1/3/8  register-file write port
- fetch_stall  out  1  combinational; holds fetch
- fetch_flush  out  1  combinational; jump redirect to fetch
- fetch_target  out  8  combinational; jump target
- halt  out  1  registered, sticky until reset
- id_valid, id_op[3:0], id_rd[2:0], id_rs1[2:0], id_rs2[2:0]  out  registered ID/EX fields
- id_a, id_b, id_imm, id_pc  out  8 each  registered operands, immediate, PC
- id_we, id_mem_rd, id_mem_wr, id_branch, id_illegal  out  1 each  registered controls

## Operation
- Formats:
  - R: op[15:12] rd[11:9] rs1[8:6] rs2[5:3]
  - I: op rd imm[7:0]
  - B: op rt[11:9] target[7:0]
  - J: op target[11:4]
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR: R format, id_we=1
  - 8 LDI: rd←imm, id_we=1
  - 9 LD: rd←mem[rs1], id_we=1, id_mem_rd=1
  - A ST: mem[rs1]←rs2, id_mem_wr=1
  - B BEQZ, C BNEZ: test rt, id_branch=1, id_imm=target
  - D JMP
  - E: illegal; issued as NOP with id_illegal=1
  - F HALT
- Operand routing:
  - id_a = R[rs1], except branches, where id_a = R[rt].
  - id_b = R[rs2].
  - id_rs1 and id_rs2 are forwarded so execute can do EX/MEM forwarding.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write-through: if wb_we and wb_rd equals a source index and is not 0, that read returns wb_data in the same cycle.
- Load-use hazard:
  - Condition: id_valid, id_mem_rd, and id_rd≠0 matching a source the current instruction actually uses.
  - Response: fetch_stall=1 for one cycle and a bubble (id_valid=0) is issued.
- Hold register:
  - Fetch drops if_valid while stalled, so decode must capture the instruction itself.
  - On the first stall cycle decode captures {if_instr, if_pc, if_valid} into an internal copy.
  - While the held copy is in use, decode works from it; the copy is cleared when it issues.
- JMP (valid, no stall, no ex_flush):
  - fetch_flush=1 and fetch_target=instr[11:4] in the same cycle.
  - JMP issues to execute as a NOP with id_valid=1.
- HALT:
  - Issues as a NOP and sets halt.
  - While halt=1: fetch_stall=1 and id_valid=0 every cycle.
  - Only reset clears halt.
- Priority: reset > ex_flush > halt > load-use stall > jump.
  - ex_flush: id_valid←0, hold register cleared, fetch_stall=0, fetch_flush=0 that cycle.
- Invalid input (if_valid=0 and no held copy): id_valid←0, all control outputs 0.

## Timing
- Latency: an instruction at the decode inputs in cycle N appears on the id_* outputs after edge N+1.
- fetch_stall, fetch_flush and fetch_target are combinational from the current or held instruction and the id_* register state.
- A load-use stall costs exactly one bubble. Operands are re-read in the next cycle, so a writeback landing that cycle is picked up.
- Reset values:
  - All id_* outputs 0, halt 0, hold register empty, register file all 0.
  - fetch_stall, fetch_flush and fetch_target are 0 while reset=1.
- Reset mid-stall or mid-halt clears everything on the next edge.
- ex_flush coinciding with a load-use or JMP: the flush wins. No stall and no redirect are issued.
- id_* fields other than the controls are don't-care when id_valid=0. The controls (id_we, id_mem_rd, id_mem_wr, id_branch, id_illegal) must be 0.

## Test plan
- R3←5 via writeback, then decode ADD R1,R3,R3 in the same cycle → id_a=5, id_b=5, id_we=1, id_op=1, with no stall.
- LD R2,[R1] followed by ADD R4,R2,R0:
  - fetch_stall=1 for exactly one cycle and one bubble is issued.
  - The ADD then issues with if_pc preserved from the hold register.
- JMP 0x3C (instr 0xD3C0) → fetch_flush=1 and fetch_target=0x3C in the same cycle. The next id_valid=1 instruction has id_pc=0x3C.
- ex_flush=1 in the same cycle as a load-use hazard → fetch_stall=0, id_valid=0 next cycle, hold register empty.
- HALT (0xF000) → halt=1 after one edge, and fetch_stall=1 persists for 10 cycles. Asserting reset then clears halt and all outputs to 0.
- Opcode 0xE → id_illegal=1, id_we=0, id_valid=1. A write to R0 followed by a read of R0 → reads 0.
